// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants and entry-type encodings, used by the dispatcher and LSB.
// The lookup helper packs {ready, value} for the dispatcher operand ports.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_BIT = 4;
  localparam int ROB_TYPE_BIT  = 2;

  typedef enum logic [ROB_TYPE_BIT-1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_EXIT   = 2'd3
  } rob_type_e;

  function automatic logic is_mispredict(input logic [ROB_TYPE_BIT-1:0] typ,
                                         input logic taken, input logic pred);
    return (typ == ROB_TYPE_BRANCH) && (taken != pred);
  endfunction

  // Stored result beats an in-flight ALU broadcast, which beats an LSB broadcast.
  function automatic logic [32:0] rob_lookup(input logic ent_ready, input logic [31:0] ent_value,
                                             input logic rs_hit, input logic [31:0] rs_val,
                                             input logic lsb_hit, input logic [31:0] lsb_val);
    logic [32:0] r;
    if (ent_ready) begin
      r = {1'b1, ent_value};
    end else if (rs_hit) begin
      r = {1'b1, rs_val};
    end else if (lsb_hit) begin
      r = {1'b1, lsb_val};
    end else begin
      r = 33'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement ring: allocates ids at the tail, captures ALU/LSB results,
// answers operand lookups with bypass, retires the head and flushes on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    issue_valid,
  input  logic [ROB_TYPE_BIT-1:0] issue_type,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_ready,
  input  logic [31:0]             issue_value,
  input  logic [31:0]             issue_alt_pc,
  output logic                    full,
  output logic [ROB_SIZE_BIT-1:0] tail_id,
  input  logic                    rs_ready,
  input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
  input  logic [31:0]             rs_value,
  input  logic                    lsb_ready,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  input  logic [31:0]             lsb_value,
  input  logic [ROB_SIZE_BIT-1:0] q1_id,
  input  logic [ROB_SIZE_BIT-1:0] q2_id,
  output logic                    q1_ready,
  output logic                    q2_ready,
  output logic [31:0]             q1_value,
  output logic [31:0]             q2_value,
  output logic                    commit_valid,
  output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
  output logic [ROB_TYPE_BIT-1:0] commit_type,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_value,
  output logic                    flush_valid,
  output logic [31:0]             flush_pc
);

  localparam int DEPTH = 1 << ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0]   CNT_FULL = {1'b1, {ROB_SIZE_BIT{1'b0}}};
  localparam logic [ROB_SIZE_BIT-1:0] ID_ONE   = {{(ROB_SIZE_BIT-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]        busy_q, busy_d, ready_q, ready_d, pred_q, pred_d;
  logic [ROB_TYPE_BIT-1:0] type_q [DEPTH];
  logic [ROB_TYPE_BIT-1:0] type_d [DEPTH];
  logic [4:0]              rd_q [DEPTH];
  logic [4:0]              rd_d [DEPTH];
  logic [31:0]             value_q [DEPTH];
  logic [31:0]             value_d [DEPTH];
  logic [31:0]             alt_pc_q [DEPTH];
  logic [31:0]             alt_pc_d [DEPTH];
  logic [ROB_SIZE_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_SIZE_BIT:0]   count_q, count_d;
  logic                    full_q, full_d;
  logic                    commit_valid_q, commit_valid_d, flush_valid_q, flush_valid_d;
  logic [ROB_SIZE_BIT-1:0] commit_rob_id_q, commit_rob_id_d;
  logic [ROB_TYPE_BIT-1:0] commit_type_q, commit_type_d;
  logic [4:0]              commit_rd_q, commit_rd_d;
  logic [31:0]             commit_value_q, commit_value_d, flush_pc_q, flush_pc_d;

  logic issue_fire_s, commit_fire_s, mispredict_s, rs_wb_s, lsb_wb_s;
  logic [32:0] q1_s, q2_s;

  // Wrong-path cycle: while a flush is visible every state-changing request is dropped.
  always_comb begin
    issue_fire_s  = issue_valid && !full_q && !flush_valid_q;
    commit_fire_s = busy_q[head_q] && ready_q[head_q] && !flush_valid_q;
    mispredict_s  = commit_fire_s && is_mispredict(type_q[head_q], value_q[head_q][0], pred_q[head_q]);
    rs_wb_s       = rs_ready && busy_q[rs_rob_id] && !ready_q[rs_rob_id] && !flush_valid_q;
    lsb_wb_s      = lsb_ready && busy_q[lsb_rob_id] && !ready_q[lsb_rob_id] && !flush_valid_q;
  end

  // Next-state for the ring, the retire path and the redirect.
  always_comb begin
    busy_d          = busy_q;
    ready_d         = ready_q;
    pred_d          = pred_q;
    type_d          = type_q;
    rd_d            = rd_q;
    value_d         = value_q;
    alt_pc_d        = alt_pc_q;
    head_d          = head_q;
    tail_d          = tail_q;
    commit_valid_d  = 1'b0;
    commit_rob_id_d = commit_rob_id_q;
    commit_type_d   = commit_type_q;
    commit_rd_d     = commit_rd_q;
    commit_value_d  = commit_value_q;
    flush_valid_d   = 1'b0;
    flush_pc_d      = flush_pc_q;
    if (rs_wb_s) begin
      ready_d[rs_rob_id] = 1'b1;
      value_d[rs_rob_id] = rs_value;
    end else begin
      ready_d = ready_d;
    end
    // Applied second so the LSB result wins a same-id collision.
    if (lsb_wb_s) begin
      ready_d[lsb_rob_id] = 1'b1;
      value_d[lsb_rob_id] = lsb_value;
    end else begin
      ready_d = ready_d;
    end
    if (issue_fire_s) begin
      busy_d[tail_q]   = 1'b1;
      ready_d[tail_q]  = issue_ready;
      type_d[tail_q]   = issue_type;
      rd_d[tail_q]     = issue_rd;
      value_d[tail_q]  = issue_value;
      pred_d[tail_q]   = (issue_type == ROB_TYPE_BRANCH) ? issue_value[0] : 1'b0;
      alt_pc_d[tail_q] = issue_alt_pc;
      tail_d           = tail_q + ID_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (commit_fire_s) begin
      busy_d[head_q]  = 1'b0;
      head_d          = head_q + ID_ONE;
      commit_valid_d  = 1'b1;
      commit_rob_id_d = head_q;
      commit_type_d   = type_q[head_q];
      commit_rd_d     = rd_q[head_q];
      commit_value_d  = value_q[head_q];
    end else begin
      head_d = head_q;
    end
    count_d = count_q + (ROB_SIZE_BIT+1)'(issue_fire_s) - (ROB_SIZE_BIT+1)'(commit_fire_s);
    if (mispredict_s) begin
      busy_d        = '0;
      ready_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      flush_valid_d = 1'b1;
      flush_pc_d    = alt_pc_q[head_q];
    end else begin
      flush_valid_d = 1'b0;
    end
    full_d = (count_d == CNT_FULL);
  end

  // State register; rdy_in low freezes everything, including the output pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q          <= '0;
      ready_q         <= '0;
      pred_q          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i]   <= '0;
        rd_q[i]     <= 5'd0;
        value_q[i]  <= 32'd0;
        alt_pc_q[i] <= 32'd0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      commit_valid_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_type_q   <= '0;
      commit_rd_q     <= 5'd0;
      commit_value_q  <= 32'd0;
      flush_valid_q   <= 1'b0;
      flush_pc_q      <= 32'd0;
    end else if (rdy_in) begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      pred_q          <= pred_d;
      type_q          <= type_d;
      rd_q            <= rd_d;
      value_q         <= value_d;
      alt_pc_q        <= alt_pc_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      full_q          <= full_d;
      commit_valid_q  <= commit_valid_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_type_q   <= commit_type_d;
      commit_rd_q     <= commit_rd_d;
      commit_value_q  <= commit_value_d;
      flush_valid_q   <= flush_valid_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  // Dispatcher operand lookups with same-cycle broadcast bypass.
  always_comb begin
    q1_s = rob_lookup(ready_q[q1_id], value_q[q1_id], rs_ready && (rs_rob_id == q1_id), rs_value,
                      lsb_ready && (lsb_rob_id == q1_id), lsb_value);
    q2_s = rob_lookup(ready_q[q2_id], value_q[q2_id], rs_ready && (rs_rob_id == q2_id), rs_value,
                      lsb_ready && (lsb_rob_id == q2_id), lsb_value);
  end

  assign q1_ready      = q1_s[32];
  assign q1_value      = q1_s[31:0];
  assign q2_ready      = q2_s[32];
  assign q2_value      = q2_s[31:0];
  assign full          = full_q;
  assign tail_id       = tail_q;
  assign commit_valid  = commit_valid_q;
  assign commit_rob_id = commit_rob_id_q;
  assign commit_type   = commit_type_q;
  assign commit_rd     = commit_rd_q;
  assign commit_value  = commit_value_q;
  assign flush_valid   = flush_valid_q;
  assign flush_pc      = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenarios plus randomized traffic against a queue-based model of the ROB.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0, rst_in, rdy_in;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_type, commit_type;
  logic [4:0]  issue_rd, commit_rd;
  logic [31:0] issue_value, issue_alt_pc, rs_value, lsb_value, q1_value, q2_value, commit_value, flush_pc;
  logic        full, rs_ready, lsb_ready, q1_ready, q2_ready, commit_valid, flush_valid;
  logic [3:0]  tail_id, rs_rob_id, lsb_rob_id, q1_id, q2_id, commit_rob_id;

  reorder_buffer #(.ROB_SIZE_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_value(issue_value), .issue_alt_pc(issue_alt_pc),
    .full(full), .tail_id(tail_id),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_type(commit_type),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .flush_valid(flush_valid), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int id; logic [1:0] typ; logic [4:0] rd; bit rdy; logic [31:0] val; bit pred; logic [31:0] alt;
  } ent_t;

  ent_t        rob[$];
  int          mtail;
  bit          flushing, e_cv, e_fv;
  int          e_cid;
  logic [1:0]  e_ctype;
  logic [4:0]  e_crd;
  logic [31:0] e_cval, e_fpc;
  int          checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input int id);
    for (int i = 0; i < rob.size(); i++) if (rob[i].id == id) return i;
    return -1;
  endfunction

  task automatic idle();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_ready = 1'b0;
    issue_value = 32'd0; issue_alt_pc = 32'd0; rs_ready = 1'b0; rs_rob_id = 4'd0; rs_value = 32'd0;
    lsb_ready = 1'b0; lsb_rob_id = 4'd0; lsb_value = 32'd0; q1_id = 4'd0; q2_id = 4'd0;
  endtask

  task automatic model_reset();
    rob.delete(); mtail = 0; flushing = 1'b0; e_cv = 1'b0; e_fv = 1'b0;
  endtask

  task automatic check_query(input string tag, input logic [3:0] qid, input logic r, input logic [31:0] v);
    int k; logic er; logic [31:0] ev;
    k = find(int'(qid));
    if (k >= 0) begin
      er = 1'b1;
      if (rob[k].rdy) ev = rob[k].val;
      else if (rs_ready && rs_rob_id == qid) ev = rs_value;
      else if (lsb_ready && lsb_rob_id == qid) ev = lsb_value;
      else begin er = 1'b0; ev = 32'd0; end
      check_eq(tag, {31'd0, r, v}, {31'd0, er, ev});
    end
  endtask

  // One clock edge of the architectural behaviour, applied to the in-order queue.
  task automatic model_edge();
    bit was_full, mis, rs_ok, lsb_ok; int kr, kl; ent_t c, n;
    if (rdy_in) begin
      if (flushing) begin
        flushing = 1'b0; e_cv = 1'b0; e_fv = 1'b0;
      end else begin
        was_full = (rob.size() == DEPTH); mis = 1'b0; e_cv = 1'b0; e_fv = 1'b0;
        if (rob.size() > 0 && rob[0].rdy) begin
          c = rob.pop_front();
          e_cv = 1'b1; e_cid = c.id; e_ctype = c.typ; e_crd = c.rd; e_cval = c.val;
          mis = (c.typ == 2'd2) && (c.val[0] != c.pred);
          e_fpc = c.alt;
        end
        kr = find(int'(rs_rob_id)); kl = find(int'(lsb_rob_id));
        rs_ok  = rs_ready && kr >= 0 && !rob[kr].rdy;
        lsb_ok = lsb_ready && kl >= 0 && !rob[kl].rdy;
        if (rs_ok)  begin rob[kr].rdy = 1'b1; rob[kr].val = rs_value; end
        if (lsb_ok) begin rob[kl].rdy = 1'b1; rob[kl].val = lsb_value; end
        if (issue_valid && !was_full) begin
          n.id = mtail; n.typ = issue_type; n.rd = issue_rd; n.rdy = issue_ready; n.val = issue_value;
          n.pred = (issue_type == 2'd2) ? issue_value[0] : 1'b0; n.alt = issue_alt_pc;
          rob.push_back(n);
          mtail = (mtail + 1) % DEPTH;
        end
        if (mis) begin
          rob.delete(); mtail = 0; flushing = 1'b1; e_fv = 1'b1;
        end
      end
    end
  endtask

  // Inputs are already driven (at a negedge); check lookups, take the edge, check outputs.
  task automatic step();
    #1;
    check_query("q1", q1_id, q1_ready, q1_value);
    check_query("q2", q2_id, q2_ready, q2_value);
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_eq("commit_valid", {63'd0, commit_valid}, {63'd0, e_cv});
    if (e_cv) begin
      check_eq("commit_id", {60'd0, commit_rob_id}, 64'(e_cid));
      check_eq("commit_type", {62'd0, commit_type}, {62'd0, e_ctype});
      check_eq("commit_value", {32'd0, commit_value}, {32'd0, e_cval});
      if (e_ctype != 2'd3) check_eq("commit_rd", {59'd0, commit_rd}, {59'd0, e_crd});
    end
    check_eq("flush_valid", {63'd0, flush_valid}, {63'd0, e_fv});
    if (e_fv) check_eq("flush_pc", {32'd0, flush_pc}, {32'd0, e_fpc});
    check_eq("full", {63'd0, full}, {63'd0, rob.size() == DEPTH});
    check_eq("tail_id", {60'd0, tail_id}, 64'(mtail));
  endtask

  task automatic check_cleared(input string tag);
    check_eq(tag, {28'd0, commit_valid, flush_valid, full, tail_id, q1_ready, q2_ready, 25'd0},
             64'd0);
  endtask

  task automatic do_reset();
    rst_in = 1'b0; idle(); model_reset();
    #1 check_cleared("reset_outputs");
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic r,
                       input logic [31:0] v, input logic [31:0] alt);
    idle(); issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_ready = r;
    issue_value = v; issue_alt_pc = alt;
    step();
  endtask

  function automatic logic [3:0] pick_id();
    if (rob.size() > 0 && $urandom_range(0, 3) != 0) return 4'(rob[$urandom_range(0, rob.size() - 1)].id);
    return 4'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    rst_in = 1'b0; idle(); model_reset();
    @(negedge clk_in);
    do_reset();

    // Reset / allocation
    for (int i = 0; i < 3; i++) issue(2'd0, 5'(5 + i), 1'b0, 32'd0, 32'd0);
    idle(); step();
    check_eq("alloc_tail", {60'd0, tail_id}, 64'd3);

    // Out-of-order writeback, in-order retire
    idle(); rs_ready = 1'b1; rs_rob_id = 4'd1; rs_value = 32'h22; step();
    idle(); rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h11; step();
    idle(); step();
    check_eq("ooo_first", {commit_valid, commit_rob_id, commit_rd, commit_value},
             {1'b1, 4'd0, 5'd5, 32'h11});
    idle(); step();
    check_eq("ooo_second", {commit_valid, commit_rob_id, commit_rd, commit_value},
             {1'b1, 4'd1, 5'd6, 32'h22});

    // Full ring, ignored 17th issue, release by one commit, wrap to id 0
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(2'd0, 5'(i), 1'b0, 32'd0, 32'd0);
    check_eq("full_set", {63'd0, full}, 64'd1);
    issue(2'd0, 5'd31, 1'b1, 32'h5, 32'd0);
    check_eq("full_ignore_tail", {60'd0, tail_id}, 64'd0);
    idle(); rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h77; step();
    idle(); step();
    check_eq("full_release", {59'd0, full, tail_id}, 64'd0);
    issue(2'd0, 5'd9, 1'b0, 32'd0, 32'd0);
    check_eq("wrap_tail", {60'd0, tail_id}, 64'd1);

    // Same-cycle bypass on a pending entry
    idle(); q1_id = 4'd2; rs_ready = 1'b1; rs_rob_id = 4'd2; rs_value = 32'hDEAD;
    #1 check_eq("bypass", {31'd0, q1_ready, q1_value}, {31'd0, 1'b1, 32'hDEAD});
    step();

    // Mispredicted branch with three ready younger entries
    do_reset();
    issue(2'd2, 5'd0, 1'b0, 32'd1, 32'h104);
    for (int i = 0; i < 3; i++) issue(2'd0, 5'(10 + i), 1'b1, 32'(i), 32'd0);
    idle(); rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'd0; step();
    idle(); step();
    check_eq("mispredict", {commit_valid, flush_valid, flush_pc}, {1'b1, 1'b1, 32'h104});
    idle(); step(); step();
    check_eq("post_flush", {58'd0, commit_valid, flush_valid, tail_id}, 64'd0);

    // Asynchronous reset between edges with live entries
    do_reset();
    for (int i = 0; i < 5; i++) issue(2'd0, 5'(i), 1'b1, 32'(100 + i), 32'd0);
    check_eq("pre_async", {63'd0, commit_valid}, 64'd1);
    #2 rst_in = 1'b0;
    #1 check_cleared("async_reset");
    model_reset(); idle();
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int t;
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      t = $urandom_range(0, 15);
      issue_type = (t == 0) ? 2'd2 : (t == 1) ? 2'd3 : (t == 2) ? 2'd1 : 2'd0;
      issue_rd = 5'($urandom); issue_ready = ($urandom_range(0, 3) == 0);
      issue_value = $urandom; issue_alt_pc = $urandom;
      rs_ready = ($urandom_range(0, 1) == 1); rs_rob_id = pick_id(); rs_value = $urandom;
      lsb_ready = ($urandom_range(0, 3) == 0); lsb_rob_id = pick_id(); lsb_value = $urandom;
      q1_id = pick_id(); q2_id = pick_id();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
